// File: rtl/des_pkg.sv
// DES key-schedule constants and helpers: PC-1/PC-2 tables, per-round shift amounts, shared types.
// Also holds the byte-parity helper used when DES_KEY_PARITY_CHECK_EN is defined.
package des_pkg;

  typedef logic [47:0] subkey_t;
  typedef logic [55:0] cd_t;
  typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} state_e;

  // Entries are FIPS 46-3 bit numbers: bit 1 is the MSB of the source vector.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT  [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int RSHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic cd_t pc1(input logic [63:0] key);
    cd_t cd;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64 - PC1_TBL[i]];
    return cd;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input int n, input logic left);
    return left ? ((x << n) | (x >> (28 - n))) : ((x >> n) | (x << (28 - n)));
  endfunction

  // C and D halves rotate independently.
  function automatic cd_t cd_rotate(input cd_t cd, input int n, input logic left);
    return {rot28(cd[55:28], n, left), rot28(cd[27:0], n, left)};
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] key);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^key[8*b +: 8]);
    return ok;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit CD register to 48-bit round subkey.
// Purely combinational so other key-schedule variants can reuse it.
module des_pc2
  import des_pkg::*;
(
  input  cd_t     cd,
  output subkey_t subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) subkey[47-i] = cd[56 - PC2_TBL[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one 48-bit subkey per valid/ready handshake, K1..K16 or K16..K1.
// Optional byte-parity rejection of keys is enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output subkey_t     subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        done,
  output logic        parity_err,
  output state_e      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // subkey/round_idx stay stable while subkey_valid is high and subkey_ready is low.
  state_e     state;
  cd_t        cd;
  logic       dir;
  logic       key_bad;
  logic [3:0] nxt_idx;
  cd_t        key_cd;

`ifdef DES_KEY_PARITY_CHECK_EN
  assign key_bad = !key_parity_ok(key_in);
`else
  assign key_bad = 1'b0;
`endif

  assign key_cd       = pc1(key_in);
  assign nxt_idx      = round_idx + 4'd1;
  assign key_ready    = (state == IDLE);
  assign subkey_valid = (state == ROUND);
  assign dbg_state    = state;

  des_pc2 u_pc2 (
    .cd     (cd),
    .subkey (subkey)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cd         <= '0;
      dir        <= 1'b0;
      round_idx  <= 4'd0;
      done       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      done       <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            if (key_bad) begin
              parity_err <= 1'b1;
            end else begin
              // Encrypt pre-applies the round-1 shift; decrypt starts from C0D0 = C16D16.
              cd        <= decrypt ? key_cd : cd_rotate(key_cd, SHIFT[0], 1'b1);
              dir       <= decrypt;
              round_idx <= 4'd0;
              state     <= ROUND;
            end
          end
        end
        ROUND: begin
          if (subkey_ready) begin
            if (round_idx == 4'd15) begin
              state     <= IDLE;
              round_idx <= 4'd0;
              done      <= 1'b1;
            end else begin
              round_idx <= nxt_idx;
              cd        <= dir ? cd_rotate(cd, RSHIFT[nxt_idx], 1'b0)
                               : cd_rotate(cd, SHIFT[nxt_idx], 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: known-answer vectors plus random keys against a
// bit-list DES key-schedule model using cumulative rotation counts.
module tb_des_key_schedule;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [63:0]       key_in = '0;
  logic              decrypt = 1'b0;
  logic              key_valid = 1'b0;
  logic              key_ready;
  logic [47:0]       subkey;
  logic              subkey_valid;
  logic              subkey_ready = 1'b0;
  logic [3:0]        round_idx;
  logic              done;
  logic              parity_err;
  des_pkg::state_e   dbg_state;

  int checks = 0;
  int failures = 0;
  logic [47:0] exp_q[$];

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

  // Independent copies of the FIPS 46-3 tables (1-based bit numbers, bit 1 = MSB).
  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int ls_t  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  des_key_schedule dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .done         (done),
    .parity_err   (parity_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // K_rnd (1..16): C and D are C0/D0 rotated left by the sum of the first rnd shift counts.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int rnd);
    logic c_bits [28];
    logic d_bits [28];
    logic cd_bits [57];
    logic [47:0] k;
    int cum;
    cum = 0;
    for (int r = 0; r < rnd; r++) cum += ls_t[r];
    for (int j = 0; j < 28; j++) begin
      c_bits[j] = key[64 - pc1_t[j]];
      d_bits[j] = key[64 - pc1_t[j + 28]];
    end
    cd_bits[0] = 1'b0;
    for (int j = 0; j < 28; j++) begin
      cd_bits[j + 1]  = c_bits[(j + cum) % 28];
      cd_bits[j + 29] = d_bits[(j + cum) % 28];
    end
    k = '0;
    for (int i = 1; i <= 48; i++) k[48 - i] = cd_bits[pc2_t[i - 1]];
    return k;
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] key);
    logic [63:0] k;
    k = key;
    for (int b = 0; b < 8; b++) k[8*b] = ~(^k[8*b+1 +: 7]);
    return k;
  endfunction

  function automatic logic [63:0] rand_key();
    return {$urandom(), $urandom()};
  endfunction

  task automatic start_key(input logic [63:0] k, input logic d);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!key_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_key_ready: got %b expected 1", key_ready);
    end
    key_in = k;
    decrypt = d;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (subkey_valid !== 1'b0 || round_idx !== 4'd0 || done !== 1'b0 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b idx=%0d done=%b perr=%b expected 0/0/0/0",
               subkey_valid, round_idx, done, parity_err);
    end
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_key_ready: got %b expected 1", key_ready);
    end
    // Abort a sequence after five subkeys.
    subkey_ready = 1'b1;
    start_key(KAT_KEY, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (round_idx !== 4'd4) begin
      failures++;
      $display("FAIL reset_mid_idx: got %0d expected 4", round_idx);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (subkey_valid !== 1'b0 || round_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_abort: valid=%b idx=%0d expected 0/0", subkey_valid, round_idx);
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_after_abort: done=%b ready=%b valid=%b expected 0/1/0",
                 done, key_ready, subkey_valid);
      end
    end
  endtask

  task automatic test_encrypt_vector();
    for (int r = 1; r <= 16; r++) exp_q.push_back(ref_subkey(KAT_KEY, r));
    subkey_ready = 1'b1;
    start_key(KAT_KEY, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [47:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (subkey_valid !== 1'b1 || round_idx !== i[3:0] || subkey !== e) begin
        failures++;
        $display("FAIL enc_subkey[%0d]: valid=%b idx=%0d key=%h expected 1/%0d/%h",
                 i, subkey_valid, round_idx, subkey, i, e);
      end
      if (i == 0 || i == 15) begin
        checks++;
        if (subkey !== ((i == 0) ? KAT_K1 : KAT_K16)) begin
          failures++;
          $display("FAIL enc_kat[%0d]: got %h expected %h", i, subkey, (i == 0) ? KAT_K1 : KAT_K16);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL enc_done: done=%b valid=%b ready=%b expected 1/0/1", done, subkey_valid, key_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL enc_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_decrypt_order();
    for (int r = 16; r >= 1; r--) exp_q.push_back(ref_subkey(KAT_KEY, r));
    subkey_ready = 1'b1;
    start_key(KAT_KEY, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic [47:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (subkey_valid !== 1'b1 || round_idx !== i[3:0] || subkey !== e) begin
        failures++;
        $display("FAIL dec_subkey[%0d]: valid=%b idx=%0d key=%h expected 1/%0d/%h",
                 i, subkey_valid, round_idx, subkey, i, e);
      end
      if (i == 0 || i == 15) begin
        checks++;
        if (subkey !== ((i == 0) ? KAT_K16 : KAT_K1)) begin
          failures++;
          $display("FAIL dec_kat[%0d]: got %h expected %h", i, subkey, (i == 0) ? KAT_K16 : KAT_K1);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL dec_done: got %b expected 1", done);
    end
  endtask

  task automatic test_backpressure(input int iter);
    logic [63:0] k;
    logic d;
    logic [47:0] ks [16];
    int hs;
    int cyc;
    logic seen_done;
    k = fix_parity(rand_key());
    d = 1'($urandom_range(0, 1));
    for (int i = 0; i < 16; i++) ks[i] = ref_subkey(k, d ? 16 - i : i + 1);
    subkey_ready = 1'b0;
    start_key(k, d);
    hs = 0;
    cyc = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        seen_done = 1'b1;
        key_valid = 1'b0;
        subkey_ready = 1'b0;
      end else begin
        checks++;
        if (subkey_valid !== 1'b1 || round_idx !== hs[3:0] || subkey !== ks[hs % 16]) begin
          failures++;
          $display("FAIL bp[%0d] hs=%0d: valid=%b idx=%0d key=%h expected 1/%0d/%h",
                   iter, hs, subkey_valid, round_idx, subkey, hs, ks[hs % 16]);
        end
        subkey_ready = 1'($urandom_range(0, 1));
        key_valid = 1'($urandom_range(0, 1));
        key_in = rand_key();
        decrypt = 1'($urandom_range(0, 1));
        if (subkey_ready) hs++;
      end
    end
    checks++;
    if (!seen_done || hs != 16) begin
      failures++;
      $display("FAIL bp_count[%0d]: done_seen=%b handshakes=%0d expected 1/16", iter, seen_done, hs);
    end
    @(negedge clk);
    checks++;
    if (subkey_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_ignored_key[%0d]: valid=%b expected 0", iter, subkey_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] k1;
    logic [63:0] k2;
    k1 = fix_parity(rand_key());
    k2 = fix_parity(rand_key());
    for (int r = 1; r <= 16; r++) exp_q.push_back(ref_subkey(k1, r));
    for (int r = 16; r >= 1; r--) exp_q.push_back(ref_subkey(k2, r));
    subkey_ready = 1'b1;
    start_key(k1, 1'b0);
    key_in = k2;
    decrypt = 1'b1;
    key_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [47:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (subkey_valid !== 1'b1 || round_idx !== i[3:0] || subkey !== e) begin
        failures++;
        $display("FAIL b2b_key1[%0d]: valid=%b idx=%0d key=%h expected 1/%0d/%h",
                 i, subkey_valid, round_idx, subkey, i, e);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: done=%b ready=%b expected 1/1", done, key_ready);
    end
    @(posedge clk);
    #1 key_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [47:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (subkey_valid !== 1'b1 || round_idx !== i[3:0] || subkey !== e) begin
        failures++;
        $display("FAIL b2b_key2[%0d]: valid=%b idx=%0d key=%h expected 1/%0d/%h",
                 i, subkey_valid, round_idx, subkey, i, e);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done2: got %b expected 1", done);
    end
  endtask

  task automatic test_random_keys(input int n);
    for (int t = 0; t < n; t++) begin
      logic [63:0] k;
      logic d;
      k = fix_parity(rand_key());
      d = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) exp_q.push_back(ref_subkey(k, d ? 16 - i : i + 1));
      subkey_ready = 1'b1;
      start_key(k, d);
      for (int i = 0; i < 16; i++) begin
        logic [47:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (subkey_valid !== 1'b1 || subkey !== e) begin
          failures++;
          $display("FAIL rand[%0d][%0d]: key=%h valid=%b sub=%h expected %h", t, i, k, subkey_valid, subkey, e);
        end
      end
    end
  endtask

  task automatic test_parity();
    logic [63:0] bad;
    bad = 64'h133457799BBCDFF0;
    subkey_ready = 1'b1;
    start_key(bad, 1'b0);
`ifdef DES_KEY_PARITY_CHECK_EN
    @(negedge clk);
    checks++;
    if (parity_err !== 1'b1 || subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL parity_reject: perr=%b valid=%b ready=%b expected 1/0/1", parity_err, subkey_valid, key_ready);
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      checks++;
      if (parity_err !== 1'b0 || subkey_valid !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL parity_quiet[%0d]: perr=%b valid=%b done=%b expected 0/0/0", i, parity_err, subkey_valid, done);
      end
    end
`else
    for (int r = 1; r <= 16; r++) exp_q.push_back(ref_subkey(bad, r));
    for (int i = 0; i < 16; i++) begin
      logic [47:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (parity_err !== 1'b0 || subkey_valid !== 1'b1 || subkey !== e) begin
        failures++;
        $display("FAIL parity_ignored[%0d]: perr=%b valid=%b key=%h expected 0/1/%h", i, parity_err, subkey_valid, subkey, e);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_ignored_done: done=%b perr=%b expected 1/0", done, parity_err);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encrypt_vector();
    test_decrypt_order();
    for (int i = 0; i < 4; i++) test_backpressure(i);
    test_back_to_back();
    test_random_keys(6);
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
